register_file: RTL

//   32 x 32-bit integer register file for the single-cycle RISC-V core; sits directly

---
 rtl/register_file.sv | 122 ++++++++++++
 1 files changed

// File: rtl/register_file.sv
// 32 x 32-bit integer register file with write-first bypass, a 31-cycle soft-clear
// sweep and an unbypassed debug read port.
module register_file #(
  parameter logic [31:0] SP_INIT = 32'h0000_1000,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        reg_write,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  input  logic        clear_req,
  output logic        clear_busy,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned NREGS  = 32;
  localparam logic [AW-1:0] SP_IDX   = AW'(2);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]   regs_q [NREGS-1:1];

  logic              wr_en_c;
  logic [AW-1:0]     wr_addr_c;
  logic [XLEN-1:0]   wr_data_c;
  logic              wr_req_c;

  // x0 has no storage; it always reads as zero
  function automatic logic [XLEN-1:0] arr_read(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if (a != '0) v = regs_q[a];
    return v;
  endfunction

  assign wr_req_c = reg_write && (rd_addr != '0);

  // Next-state: clear request outranks a same-edge write; the sweep owns the write port
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en_c   = 1'b0;
    wr_addr_c = rd_addr;
    wr_data_c = rd_data;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = AW'(1);
        end else if (wr_req_c) begin
          wr_en_c = 1'b1;
        end
      end
      CLEAR: begin
        wr_en_c   = 1'b1;
        wr_addr_c = idx_q;
        wr_data_c = (idx_q == SP_IDX) ? SP_INIT : '0;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = AW'(1);
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = AW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        regs_q[i] <= (i == int'(SP_IDX)) ? SP_INIT : '0;
      end
    end else if (wr_en_c) begin
      regs_q[wr_addr_c] <= wr_data_c;
    end
  end

  assign clear_busy = (state_q == CLEAR);

  // Operand ports go quiet during the sweep; otherwise optional write-first forwarding
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (state_q == IDLE) begin
      rs1_data = arr_read(rs1_addr);
      rs2_data = arr_read(rs2_addr);
      if (BYPASS && wr_req_c && (rd_addr == rs1_addr)) rs1_data = rd_data;
      if (BYPASS && wr_req_c && (rd_addr == rs2_addr)) rs2_data = rd_data;
    end
  end

  assign dbg_data = arr_read(dbg_addr);

endmodule
